// File: rtl/robot_nav_pkg.sv
// Shared types and helpers for the robot navigation controller.
package robot_nav_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 4'd0,
    S_PLAN    = 4'd1,
    S_MOVE    = 4'd2,
    S_AVOID   = 4'd3,
    S_DELIVER = 4'd4,
    S_DOCK    = 4'd5,
    S_CHARGE  = 4'd6,
    S_RECOVER = 4'd7,
    S_FAULT   = 4'd8
  } nav_state_t;

  // Width needed to hold values 0..max inclusive.
  function automatic int unsigned cnt_w(input int unsigned max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/robot_nav_if.sv
// Task scheduler handshake: task offer/accept and completion report.
interface robot_nav_if #(
  parameter int unsigned TASK_W = 4
) ();

  logic              task_valid;
  logic [TASK_W-1:0] task_id;
  logic              task_ready;
  logic              done_valid;
  logic [TASK_W-1:0] done_id;
  logic              done_ok;

  modport master (
    output task_valid, task_id,
    input  task_ready, done_valid, done_id, done_ok
  );

  modport slave (
    input  task_valid, task_id,
    output task_ready, done_valid, done_id, done_ok
  );

endinterface

// File: rtl/robot_nav_timer.sv
// Down-counting cycle timer: load starts a CYCLES-long window, expire marks its last cycle.
module nav_timer
  import robot_nav_pkg::*;
#(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_tick,
  output logic o_expire_c
);

  localparam int unsigned CW = cnt_w(CYCLES);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(CYCLES - 1);
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expire_c = (r_cnt == '0);

endmodule

// File: rtl/robot_nav_ctrl.sv
// Robot navigation controller: task handshake, obstacle detours, dock/charge, bounded recovery.
// Optional event counters are built when ROBOT_NAV_STATS_EN is defined.
module robot_nav_ctrl
  import robot_nav_pkg::*;
#(
  parameter int unsigned NUM_SENSORS     = 8,
  parameter int unsigned TASK_W          = 4,
  parameter int unsigned BATT_W          = 8,
  parameter int unsigned BATT_LOW        = 32,
  parameter int unsigned BATT_FULL       = 240,
  parameter int unsigned DETOUR_CYCLES   = 16,
  parameter int unsigned RECOVERY_CYCLES = 8,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  robot_nav_if.slave             bus,
  input  logic [NUM_SENSORS-1:0] sensor_hit,
  input  logic                   dest_reached,
  input  logic                   dock_reached,
  input  logic [BATT_W-1:0]      batt_level,
  input  logic                   error_detected,
  output logic                   drive,
  output logic                   detour,
  output logic [NUM_SENSORS-1:0] obstacle_mask,
  output logic                   deliver,
  output logic                   charging,
  output logic                   recovering,
  output logic                   fault,
  output logic [STATE_W-1:0]     state
`ifdef ROBOT_NAV_STATS_EN
  ,
  output logic [15:0]            obstacle_events,
  output logic [15:0]            recovery_events
`endif
);

  localparam int unsigned       RW       = cnt_w(MAX_RETRY);
  localparam logic [BATT_W-1:0] LOW_L    = BATT_W'(BATT_LOW);
  localparam logic [BATT_W-1:0] FULL_L   = BATT_W'(BATT_FULL);
  localparam logic [RW-1:0]     MAX_L    = RW'(MAX_RETRY);
  localparam logic [RW-1:0]     MAX_M1_L = RW'(MAX_RETRY - 1);

  nav_state_t r_state, w_next;

  logic w_accept, w_det_load, w_rec_load, w_obs_clr, w_obs_inc;
  logic w_rec_clr, w_rec_inc, w_done, w_done_ok, w_mask_load;
  logic w_det_exp, w_rec_exp, w_batt_low, w_batt_full, w_low_zone;
  logic w_drive, w_detour, w_deliver, w_charging, w_recovering, w_fault, w_task_ready;

  logic                   r_task_active;
  logic [TASK_W-1:0]      r_task_id;
  logic [RW-1:0]          r_obs_retry, r_rec_retry;
  logic [NUM_SENSORS-1:0] r_mask;
  logic                   r_done_valid, r_done_ok;
  logic [TASK_W-1:0]      r_done_id;
  logic r_drive, r_detour, r_deliver, r_charging, r_recovering, r_fault, r_task_ready;

  assign w_batt_low  = (batt_level < LOW_L);
  assign w_batt_full = (batt_level >= FULL_L);
  assign w_low_zone  = (r_state == S_IDLE) || (r_state == S_PLAN) ||
                       (r_state == S_MOVE) || (r_state == S_AVOID);

  nav_timer #(.CYCLES(DETOUR_CYCLES)) u_detour_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_det_load),
    .i_tick     (r_state == S_AVOID),
    .o_expire_c (w_det_exp)
  );

  nav_timer #(.CYCLES(RECOVERY_CYCLES)) u_recovery_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_rec_load),
    .i_tick     (r_state == S_RECOVER),
    .o_expire_c (w_rec_exp)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state plus datapath strobes; global rules are checked ahead of per-state rules.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_det_load  = 1'b0;
    w_rec_load  = 1'b0;
    w_obs_clr   = 1'b0;
    w_obs_inc   = 1'b0;
    w_rec_clr   = 1'b0;
    w_rec_inc   = 1'b0;
    w_done      = 1'b0;
    w_done_ok   = 1'b0;
    w_mask_load = 1'b0;
    if (r_state == S_FAULT) begin
      w_next = S_FAULT;
    end else if (error_detected && (r_state != S_RECOVER) && (r_state <= S_FAULT)) begin
      w_next     = S_RECOVER;
      w_rec_load = 1'b1;
      w_rec_clr  = 1'b1;
    end else if (w_batt_low && w_low_zone) begin
      w_next    = S_DOCK;
      w_obs_clr = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.task_valid && r_task_ready) begin
            w_accept = 1'b1;
            w_next   = S_PLAN;
          end
        end
        S_PLAN: w_next = S_MOVE;
        S_MOVE: begin
          if (|sensor_hit) begin
            w_next      = S_AVOID;
            w_mask_load = 1'b1;
            w_det_load  = 1'b1;
            w_obs_inc   = 1'b1;
          end else if (dest_reached) begin
            w_next = S_DELIVER;
          end
        end
        S_AVOID: begin
          if (w_det_exp) begin
            if (sensor_hit == '0) begin
              w_next    = S_PLAN;
              w_obs_clr = 1'b1;
            end else if (r_obs_retry < MAX_L) begin
              w_det_load = 1'b1;
              w_obs_inc  = 1'b1;
            end else begin
              w_next    = S_IDLE;
              w_obs_clr = 1'b1;
              w_done    = r_task_active;
            end
          end
        end
        S_DELIVER: begin
          w_next    = S_IDLE;
          w_done    = r_task_active;
          w_done_ok = 1'b1;
        end
        S_DOCK: begin
          if (dock_reached) w_next = S_CHARGE;
        end
        S_CHARGE: begin
          if (w_batt_full) w_next = r_task_active ? S_PLAN : S_IDLE;
        end
        S_RECOVER: begin
          if (w_rec_exp) begin
            if (!error_detected) begin
              w_next = r_task_active ? S_PLAN : S_IDLE;
            end else if (r_rec_retry < MAX_M1_L) begin
              w_rec_inc  = 1'b1;
              w_rec_load = 1'b1;
            end else begin
              w_next = S_FAULT;
              w_done = r_task_active;
            end
          end
        end
        default: w_next = S_FAULT;
      endcase
    end
  end

  // Moore outputs decoded from the upcoming state so the registered copies line up with r_state.
  always_comb begin
    w_drive      = 1'b0;
    w_detour     = 1'b0;
    w_deliver    = 1'b0;
    w_charging   = 1'b0;
    w_recovering = 1'b0;
    w_fault      = 1'b0;
    w_task_ready = 1'b0;
    case (w_next)
      S_IDLE:    w_task_ready = 1'b1;
      S_MOVE:    w_drive      = 1'b1;
      S_AVOID:   w_detour     = 1'b1;
      S_DELIVER: w_deliver    = 1'b1;
      S_DOCK:    w_drive      = 1'b1;
      S_CHARGE:  w_charging   = 1'b1;
      S_RECOVER: w_recovering = 1'b1;
      S_FAULT:   w_fault      = 1'b1;
      default:   w_fault      = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drive       <= 1'b0;
      r_detour      <= 1'b0;
      r_deliver     <= 1'b0;
      r_charging    <= 1'b0;
      r_recovering  <= 1'b0;
      r_fault       <= 1'b0;
      r_task_ready  <= 1'b1;
      r_task_active <= 1'b0;
      r_task_id     <= '0;
      r_obs_retry   <= '0;
      r_rec_retry   <= '0;
      r_mask        <= '0;
      r_done_valid  <= 1'b0;
      r_done_id     <= '0;
      r_done_ok     <= 1'b0;
    end else begin
      r_drive      <= w_drive;
      r_detour     <= w_detour;
      r_deliver    <= w_deliver;
      r_charging   <= w_charging;
      r_recovering <= w_recovering;
      r_fault      <= w_fault;
      r_task_ready <= w_task_ready;
      r_done_valid <= w_done;
      if (w_accept) begin
        r_task_active <= 1'b1;
        r_task_id     <= bus.task_id;
      end else if (w_done) begin
        r_task_active <= 1'b0;
      end
      if (w_done) begin
        r_done_id <= r_task_id;
        r_done_ok <= w_done_ok;
      end
      if (w_mask_load) r_mask <= sensor_hit;
      if (w_obs_clr)                             r_obs_retry <= '0;
      else if (w_obs_inc && (r_obs_retry < MAX_L)) r_obs_retry <= r_obs_retry + RW'(1);
      if (w_rec_clr)                             r_rec_retry <= '0;
      else if (w_rec_inc && (r_rec_retry < MAX_L)) r_rec_retry <= r_rec_retry + RW'(1);
    end
  end

`ifdef ROBOT_NAV_STATS_EN
  logic [15:0] r_obs_events, r_rec_events;

  // Saturating event counters for AVOID entries from MOVE and RECOVER entries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_obs_events <= '0;
      r_rec_events <= '0;
    end else begin
      if (w_mask_load && (r_obs_events != 16'hFFFF)) r_obs_events <= r_obs_events + 16'd1;
      if (w_rec_clr && (r_rec_events != 16'hFFFF))   r_rec_events <= r_rec_events + 16'd1;
    end
  end

  assign obstacle_events = r_obs_events;
  assign recovery_events = r_rec_events;
`endif

  assign drive          = r_drive;
  assign detour         = r_detour;
  assign obstacle_mask  = r_mask;
  assign deliver        = r_deliver;
  assign charging       = r_charging;
  assign recovering     = r_recovering;
  assign fault          = r_fault;
  assign state          = r_state;
  assign bus.task_ready = r_task_ready;
  assign bus.done_valid = r_done_valid;
  assign bus.done_id    = r_done_id;
  assign bus.done_ok    = r_done_ok;

endmodule

// File: tb/tb_robot_nav_ctrl.sv
// Directed bench for robot_nav_ctrl; completion reports are checked against a scoreboard queue.
module tb_robot_nav_ctrl;

  logic       clk;
  logic       reset_n;
  logic [7:0] sensor_hit;
  logic       dest_reached;
  logic       dock_reached;
  logic [7:0] batt_level;
  logic       error_detected;
  logic       drive, detour, deliver, charging, recovering, fault;
  logic [7:0] obstacle_mask;
  logic [3:0] state;
`ifdef ROBOT_NAV_STATS_EN
  logic [15:0] obstacle_events, recovery_events;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] id;
    logic       ok;
  } done_exp_t;

  done_exp_t sb_q[$];

  robot_nav_if #(.TASK_W(4)) bus ();

  robot_nav_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .sensor_hit     (sensor_hit),
    .dest_reached   (dest_reached),
    .dock_reached   (dock_reached),
    .batt_level     (batt_level),
    .error_detected (error_detected),
    .drive          (drive),
    .detour         (detour),
    .obstacle_mask  (obstacle_mask),
    .deliver        (deliver),
    .charging       (charging),
    .recovering     (recovering),
    .fault          (fault),
    .state          (state)
`ifdef ROBOT_NAV_STATS_EN
    ,
    .obstacle_events(obstacle_events),
    .recovery_events(recovery_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_done(input logic [3:0] id, input logic ok);
    done_exp_t e;
    e.id = id;
    e.ok = ok;
    sb_q.push_back(e);
  endtask

  // Offer a task in IDLE and walk it through PLAN into MOVE.
  task automatic start_task(input logic [3:0] id);
    bus.task_valid = 1'b1;
    bus.task_id    = id;
    tick();
    chk("accept_plan", int'(state), 1);
    bus.task_valid = 1'b0;
    tick();
    chk("plan_to_move", int'(state), 2);
  endtask

  task automatic count_state(input logic [3:0] s, output int n);
    n = 0;
    while ((state == s) && (n < 200)) begin
      n++;
      tick();
    end
  endtask

  // Monitor: each done pulse pops the oldest expected completion.
  initial begin
    done_exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got id=%0d ok=%0d expected no pulse", bus.done_id, bus.done_ok);
        end else begin
          e = sb_q.pop_front();
          chk("done_id", int'(bus.done_id), int'(e.id));
          chk("done_ok", int'(bus.done_ok), int'(e.ok));
        end
      end
    end
  end

  initial begin
    int n;
    reset_n        = 1'b0;
    bus.task_valid = 1'b0;
    bus.task_id    = '0;
    sensor_hit     = '0;
    dest_reached   = 1'b0;
    dock_reached   = 1'b0;
    batt_level     = 8'd200;
    error_detected = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_task_ready", int'(bus.task_ready), 1);
    chk("rst_drive", int'(drive), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_done_valid", int'(bus.done_valid), 0);
    reset_n = 1'b1;

    // Delivery with dest_reached on the 4th MOVE cycle.
    expect_done(4'd5, 1'b1);
    start_task(4'd5);
    chk("move_drive", int'(drive), 1);
    tick(); tick(); tick();
    chk("move_4th", int'(state), 2);
    dest_reached = 1'b1;
    tick();
    dest_reached = 1'b0;
    chk("deliver_state", int'(state), 4);
    chk("deliver_out", int'(deliver), 1);
    tick();
    chk("deliver_idle", int'(state), 0);
    chk("idle_ready", int'(bus.task_ready), 1);

    // Single transient obstacle: one 16-cycle detour then replan.
    expect_done(4'd3, 1'b1);
    start_task(4'd3);
    sensor_hit = 8'h04;
    tick();
    sensor_hit = 8'h00;
    chk("avoid_state", int'(state), 3);
    chk("avoid_mask", int'(obstacle_mask), 4);
    n = 0;
    while ((detour == 1'b1) && (n < 200)) begin
      n++;
      tick();
    end
    chk("detour_cycles", n, 16);
    chk("avoid_to_plan", int'(state), 1);
    tick();
    chk("replan_move", int'(state), 2);
    dest_reached = 1'b1;
    tick();
    dest_reached = 1'b0;
    tick();
    chk("obs_deliver_idle", int'(state), 0);

    // Persistent obstacle: three detours then abort.
    expect_done(4'd7, 1'b0);
    start_task(4'd7);
    sensor_hit = 8'h01;
    tick();
    chk("persist_mask", int'(obstacle_mask), 1);
    count_state(4'd3, n);
    sensor_hit = 8'h00;
    chk("retry_cycles", n, 48);
    chk("retry_abort_idle", int'(state), 0);

    // Low battery: dock, charge, resume the retained task.
    expect_done(4'd2, 1'b1);
    start_task(4'd2);
    batt_level = 8'd20;
    tick();
    chk("dock_state", int'(state), 5);
    chk("dock_drive", int'(drive), 1);
    dock_reached = 1'b1;
    tick();
    dock_reached = 1'b0;
    chk("charge_state", int'(state), 6);
    chk("charging_out", int'(charging), 1);
    batt_level = 8'd239;
    tick();
    chk("charge_hold", int'(state), 6);
    batt_level = 8'd240;
    tick();
    chk("charge_to_plan", int'(state), 1);
    tick();
    chk("resume_move", int'(state), 2);
    dest_reached = 1'b1;
    tick();
    dest_reached = 1'b0;
    tick();
    chk("resume_idle", int'(state), 0);

    // Persistent error: three recovery attempts, then sticky FAULT.
    expect_done(4'd9, 1'b0);
    start_task(4'd9);
    error_detected = 1'b1;
    tick();
    chk("recover_state", int'(state), 7);
    chk("recovering_out", int'(recovering), 1);
    count_state(4'd7, n);
    chk("recover_cycles", n, 24);
    chk("fault_state", int'(state), 8);
    chk("fault_out", int'(fault), 1);
    error_detected = 1'b0;
    bus.task_valid = 1'b1;
    bus.task_id    = 4'd1;
    repeat (5) tick();
    bus.task_valid = 1'b0;
    chk("fault_sticky", int'(state), 8);
    chk("fault_no_ready", int'(bus.task_ready), 0);
    reset_n = 1'b0;
    #2;
    chk("fault_cleared", int'(fault), 0);
    chk("fault_rst_state", int'(state), 0);
    tick();
    reset_n = 1'b1;

    // Error, low battery and an offered task together in IDLE: recovery wins.
    error_detected = 1'b1;
    batt_level     = 8'd20;
    bus.task_valid = 1'b1;
    bus.task_id    = 4'd4;
    tick();
    error_detected = 1'b0;
    batt_level     = 8'd200;
    bus.task_valid = 1'b0;
    chk("prio_recover", int'(state), 7);
    chk("prio_no_ready", int'(bus.task_ready), 0);
    count_state(4'd7, n);
    chk("prio_recover_cycles", n, 8);
    chk("prio_back_idle", int'(state), 0);

    repeat (4) tick();
    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/robot_nav_ctrl.md
Name: robot_nav_ctrl

Overview:
Parametrised successor to the single-task robot navigation FSM. Adds the following on top of the basic walk/collide/deliver/recover loop:
- a task accept handshake with task ID and completion status
- N-channel obstacle sensing with timed detours and bounded retries
- battery monitoring with return-to-dock and charge
- bounded error-recovery attempts ending in a sticky FAULT
Sits between the task scheduler and the motion and sensor front-ends.

Parameters:
NUM_SENSORS, 8, width of obstacle sensor vector
TASK_W, 4, task ID width
BATT_W, 8, battery level width
BATT_LOW, 32, level strictly below which the robot returns to dock
BATT_FULL, 240, level at or above which charging ends
DETOUR_CYCLES, 16, cycles spent in one detour attempt (>=1)
RECOVERY_CYCLES, 8, cycles per recovery attempt (>=1)
MAX_RETRY, 3, maximum detour attempts and maximum recovery attempts (>=1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
task_valid  in  1  scheduler offers a task
task_id  in  TASK_W  ID of the offered task
task_ready  out  1  controller can accept a task
sensor_hit  in  NUM_SENSORS  per-channel obstacle flags
dest_reached  in  1  destination reached
dock_reached  in  1  charging dock reached
batt_level  in  BATT_W  unsigned battery level
error_detected  in  1  malfunction flag (level)
drive  out  1  drive motors toward target or dock
detour  out  1  executing a detour
obstacle_mask  out  NUM_SENSORS  sensor_hit latched on AVOID entry
deliver  out  1  delivery action
charging  out  1  charging in progress
recovering  out  1  recovery in progress
fault  out  1  sticky fault
done_valid  out  1  one-cycle task completion pulse
done_id  out  TASK_W  ID of the completed task
done_ok  out  1  1 = delivered, 0 = aborted
state  out  4  current state encoding

Behaviour:
- Reset state: IDLE. All outputs 0 except task_ready=1. All counters, latches, task_active and task IDs cleared. Reset mid-operation discards the active task with no done pulse.
- States: IDLE=0, PLAN=1, MOVE=2, AVOID=3, DELIVER=4, DOCK=5, CHARGE=6, RECOVER=7, FAULT=8. Codes 9-15 go to FAULT on the next cycle.
- Transition priority each cycle, highest first:
  1. FAULT holds until reset.
  2. error_detected in any state other than RECOVER/FAULT: go to RECOVER, recovery timer loaded, rec_retry=0.
  3. batt_level<BATT_LOW in IDLE/PLAN/MOVE/AVOID: go to DOCK. Any active task is retained and the AVOID retry count is cleared.
  4. State-specific rules below.
- IDLE: task_ready=1. On task_valid&&task_ready, latch task_id, set task_active, go to PLAN. If rule 2 or 3 fires in that cycle, no accept occurs.
- PLAN: one cycle, then MOVE.
- MOVE: drive=1.
  - Any sensor_hit bit set: go to AVOID, latch obstacle_mask, load detour timer, obs_retry++.
  - Else dest_reached: go to DELIVER.
  - Sensors take precedence over dest_reached.
- AVOID: detour=1 for exactly DETOUR_CYCLES cycles. On expiry:
  - sensor_hit==0: go to PLAN, obs_retry=0.
  - Hit persists and obs_retry<MAX_RETRY: reload the timer and increment obs_retry.
  - Hit persists and obs_retry==MAX_RETRY: go to IDLE with done_valid=1, done_ok=0; clear task_active.
- DELIVER: deliver=1 for one cycle, then go to IDLE with done_valid=1, done_ok=1; clear task_active.
- DOCK: drive=1. dock_reached: go to CHARGE.
- CHARGE: charging=1. batt_level>=BATT_FULL: go to PLAN if task_active, else IDLE.
- RECOVER: recovering=1 for RECOVERY_CYCLES cycles per attempt. On expiry:
  - error_detected==0: go to PLAN if task_active, else IDLE.
  - Error persists and rec_retry+1<MAX_RETRY: rec_retry++ and restart the attempt.
  - Otherwise: go to FAULT. fault=1 is sticky. If a task was active, pulse done_valid with done_ok=0 on FAULT entry.
- Outputs are Moore-decoded from state, except the done_* signals, which are registered one-cycle pulses. done_id holds its value between pulses.
- Counter widths: $clog2(max+1). Counters never wrap; the compare happens before the increment.

Optional Feature:
ROBOT_NAV_STATS_EN
- Defined: adds output ports obstacle_events[15:0] (incremented on each AVOID entry from MOVE) and recovery_events[15:0] (incremented on each RECOVER entry). Both saturate at 16'hFFFF and are cleared by reset.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package robot_nav_pkg holds:
  - nav_state_t enum (4-bit, codes as above)
  - STATE_W=4 constant
  - a helper function cnt_w(max) returning $clog2(max+1)
- Sub-module nav_timer (parameter CYCLES; load, tick, expire) is instantiated twice: detour and recovery.

Test Plan:
- Reset, then task_valid=1 id=5, dest_reached on 4th MOVE cycle -> IDLE→PLAN→MOVE→DELIVER→IDLE; done_valid=1, done_id=5, done_ok=1.
- In MOVE, sensor_hit=8'h04 for one cycle -> AVOID with obstacle_mask=8'h04 and detour high 16 cycles, then PLAN, then MOVE.
- sensor_hit held 8'h01 in MOVE with MAX_RETRY=3 -> 3 detours (48 cycles), then IDLE with done_ok=0.
- batt_level=20 during MOVE with task id=2 -> DOCK; dock_reached -> CHARGE; batt_level=240 -> PLAN with task id=2 retained.
- error_detected held high from MOVE -> 3 recover attempts of 8 cycles, then FAULT sticky; done_ok=0 pulse; only reset_n clears it.
- error_detected asserted in the same cycle as batt_level<BATT_LOW and task_valid in IDLE -> RECOVER; no task accepted.
